// File: rtl/chisq_out_sched.sv
// Round-robin scheduler merging three fitter lanes' chisq results onto one output stream.
// Optional build macro CHISQ_CUT_EN adds a chisq threshold cut with a rejected-result counter.
module chisq_out_sched #(
    parameter int CHISQBITS  = 32,
    parameter int TAGBITS    = 8,
    parameter int OVFCNTBITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             lane_valid,
    output logic [2:0]             lane_ready,
    input  logic [3*CHISQBITS-1:0] lane_chisq,
    input  logic [2:0]             lane_ovf,
    input  logic [3*TAGBITS-1:0]   lane_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHISQBITS-1:0]   out_chisq,
    output logic [1:0]             out_sel,
    output logic [TAGBITS-1:0]     out_tag,
    output logic [OVFCNTBITS-1:0]  ovf_cnt,
    output logic                   busy
`ifdef CHISQ_CUT_EN
    ,
    input  logic [CHISQBITS-1:0]   cut_thr,
    output logic [15:0]            rej_cnt
`endif
);

    logic [2:0]            r_lane_full;
    logic [CHISQBITS-1:0]  r_hold_chisq [3];
    logic [TAGBITS-1:0]    r_hold_tag [3];
    logic [1:0]            r_last_grant;
    logic                  r_out_valid;
    logic [CHISQBITS-1:0]  r_out_chisq;
    logic [1:0]            r_out_sel;
    logic [TAGBITS-1:0]    r_out_tag;
    logic [OVFCNTBITS-1:0] r_ovf_cnt;

    logic [2:0]            w_accept;
    logic                  w_load_en;
    logic [1:0]            w_grant;
    logic [2:0]            w_clr;
    logic                  w_drop;
    logic [1:0]            w_ovf_inc;
    logic [OVFCNTBITS:0]   w_ovf_sum;

    assign w_accept  = lane_valid & ~r_lane_full;
    assign w_load_en = (~r_out_valid | out_ready) & (|r_lane_full);

    // Search order starts one past the last granted lane so every lane gets a turn.
    always_comb begin
        w_grant = 2'd0;
        unique case (r_last_grant)
            2'd0:    w_grant = r_lane_full[1] ? 2'd1 : (r_lane_full[2] ? 2'd2 : 2'd0);
            2'd1:    w_grant = r_lane_full[2] ? 2'd2 : (r_lane_full[0] ? 2'd0 : 2'd1);
            default: w_grant = r_lane_full[0] ? 2'd0 : (r_lane_full[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign w_clr     = w_load_en ? (3'b001 << w_grant) : 3'b000;
    assign w_ovf_inc = {1'b0, w_accept[0] & lane_ovf[0]}
                     + {1'b0, w_accept[1] & lane_ovf[1]}
                     + {1'b0, w_accept[2] & lane_ovf[2]};
    assign w_ovf_sum = {1'b0, r_ovf_cnt} + {{(OVFCNTBITS-1){1'b0}}, w_ovf_inc};

`ifdef CHISQ_CUT_EN
    logic [15:0] r_rej_cnt;

    assign w_drop  = w_load_en & (r_hold_chisq[w_grant] > cut_thr);
    assign rej_cnt = r_rej_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rej_cnt <= '0;
        end else if (w_drop && (r_rej_cnt != 16'hFFFF)) begin
            r_rej_cnt <= r_rej_cnt + 16'd1;
        end
    end
`else
    assign w_drop = 1'b0;
`endif

    // Lane holding registers; an overflowed result is stored already saturated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane_full <= '0;
            for (int i = 0; i < 3; i++) begin
                r_hold_chisq[i] <= '0;
                r_hold_tag[i]   <= '0;
            end
        end else begin
            r_lane_full <= (r_lane_full & ~w_clr) | w_accept;
            for (int i = 0; i < 3; i++) begin
                if (w_accept[i]) begin
                    r_hold_chisq[i] <= lane_ovf[i] ? {CHISQBITS{1'b1}}
                                                   : lane_chisq[i*CHISQBITS +: CHISQBITS];
                    r_hold_tag[i]   <= lane_tag[i*TAGBITS +: TAGBITS];
                end
            end
        end
    end

    // A dropped result still consumes the grant slot and advances the rotation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 2'd2;
            r_out_valid  <= 1'b0;
            r_out_chisq  <= '0;
            r_out_sel    <= 2'd0;
            r_out_tag    <= '0;
        end else begin
            if (w_load_en) begin
                r_last_grant <= w_grant;
            end
            if (w_load_en && !w_drop) begin
                r_out_valid <= 1'b1;
                r_out_chisq <= r_hold_chisq[w_grant];
                r_out_sel   <= w_grant;
                r_out_tag   <= r_hold_tag[w_grant];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
        end else if (w_ovf_sum[OVFCNTBITS]) begin
            r_ovf_cnt <= '1;
        end else begin
            r_ovf_cnt <= w_ovf_sum[OVFCNTBITS-1:0];
        end
    end

    assign lane_ready = ~r_lane_full;
    assign out_valid  = r_out_valid;
    assign out_chisq  = r_out_chisq;
    assign out_sel    = r_out_sel;
    assign out_tag    = r_out_tag;
    assign ovf_cnt    = r_ovf_cnt;
    assign busy       = (|r_lane_full) | r_out_valid;

endmodule

// File: tb/tb_chisq_out_sched.sv
// Directed testbench for chisq_out_sched; define CHISQ_CUT_EN to also exercise the threshold cut.
module tb_chisq_out_sched;

    logic        clk;
    logic        reset_n;
    logic [2:0]  laneValid;
    logic [2:0]  laneReady;
    logic [95:0] laneChisq;
    logic [2:0]  laneOvf;
    logic [23:0] laneTag;
    logic        outValid;
    logic        outReady;
    logic [31:0] outChisq;
    logic [1:0]  outSel;
    logic [7:0]  outTag;
    logic [15:0] ovfCnt;
    logic        busy;
`ifdef CHISQ_CUT_EN
    logic [31:0] cutThr;
    logic [15:0] rejCnt;
`endif

    int checks   = 0;
    int failures = 0;

    chisq_out_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lane_valid (laneValid),
        .lane_ready (laneReady),
        .lane_chisq (laneChisq),
        .lane_ovf   (laneOvf),
        .lane_tag   (laneTag),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_chisq  (outChisq),
        .out_sel    (outSel),
        .out_tag    (outTag),
        .ovf_cnt    (ovfCnt),
        .busy       (busy)
`ifdef CHISQ_CUT_EN
        ,
        .cut_thr    (cutThr),
        .rej_cnt    (rejCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] ovf,
                                 input logic [31:0] c0, input logic [31:0] c1,
                                 input logic [31:0] c2, input logic [7:0] t0,
                                 input logic [7:0] t1, input logic [7:0] t2);
        laneValid = valid;
        laneOvf   = ovf;
        laneChisq = {c2, c1, c0};
        laneTag   = {t2, t1, t0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        outReady = 1'b1;
`ifdef CHISQ_CUT_EN
        cutThr   = 32'hFFFF_FFFF;
`endif
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset values
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_lane_ready", laneReady, 3'b111);
        checkOutput("rst_out_chisq", outChisq, 0);
        checkOutput("rst_out_sel", outSel, 0);
        checkOutput("rst_out_tag", outTag, 0);
        checkOutput("rst_ovf_cnt", ovfCnt, 0);
        checkOutput("rst_busy", busy, 0);

        // Single result on lane 1
        applyStimulus(3'b010, 3'b000, 0, 32'h0000_0100, 0, 0, 8'h5A, 0);
        tick();
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        checkOutput("single_ready_e1", laneReady, 3'b101);
        checkOutput("single_valid_e1", outValid, 0);
        checkOutput("single_busy_e1", busy, 1);
        tick();
        checkOutput("single_valid_e2", outValid, 1);
        checkOutput("single_chisq", outChisq, 32'h0000_0100);
        checkOutput("single_sel", outSel, 2'b01);
        checkOutput("single_tag", outTag, 8'h5A);
        checkOutput("single_ready_e2", laneReady, 3'b111);
        tick();
        checkOutput("single_drain", outValid, 0);

        // Overflow saturation on lane 2
        applyStimulus(3'b100, 3'b100, 0, 0, 32'h0000_1234, 0, 0, 8'h33);
        tick();
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        checkOutput("ovf_cnt_1", ovfCnt, 1);
        tick();
        checkOutput("ovf_valid", outValid, 1);
        checkOutput("ovf_chisq", outChisq, 32'hFFFF_FFFF);
        checkOutput("ovf_sel", outSel, 2'b10);
        checkOutput("ovf_tag", outTag, 8'h33);
        tick();
        checkOutput("ovf_drain", outValid, 0);

        // Fairness: all lanes valid every cycle
        applyStimulus(3'b111, 3'b000, 32'h10, 32'h11, 32'h12, 8'h10, 8'h11, 8'h12);
        tick();
        checkOutput("fair_first_valid", outValid, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("fair_valid", outValid, 1);
            checkOutput("fair_sel", outSel, k % 3);
            checkOutput("fair_chisq", outChisq, 32'h10 + (k % 3));
        end
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("fair_tail_sel0", outSel, 0);
        tick();
        checkOutput("fair_tail_sel1", outSel, 1);
        tick();
        checkOutput("fair_drain_valid", outValid, 0);
        checkOutput("fair_drain_ready", laneReady, 3'b111);

        // Backpressure with all lanes full
        outReady = 1'b0;
        applyStimulus(3'b111, 3'b000, 32'h20, 32'h21, 32'h22, 8'h20, 8'h21, 8'h22);
        tick();
        checkOutput("bp_accept_ready", laneReady, 3'b000);
        tick();
        checkOutput("bp_first_sel", outSel, 2'b10);
        checkOutput("bp_first_ready", laneReady, 3'b100);
        tick();
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("bp_hold_valid", outValid, 1);
            checkOutput("bp_hold_sel", outSel, 2'b10);
            checkOutput("bp_hold_chisq", outChisq, 32'h22);
            checkOutput("bp_hold_ready", laneReady, 3'b000);
        end
        outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp_rel_valid", outValid, 1);
            checkOutput("bp_rel_sel", outSel, k);
            checkOutput("bp_rel_chisq", outChisq, 32'h20 + k);
        end
        tick();
        checkOutput("bp_drain", outValid, 0);

        // Async reset mid-stream
        outReady = 1'b0;
        applyStimulus(3'b111, 3'b000, 32'h30, 32'h31, 32'h32, 0, 0, 0);
        tick();
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("ar_pre_valid", outValid, 1);
        checkOutput("ar_pre_ready", laneReady, 3'b001);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("ar_valid", outValid, 0);
        checkOutput("ar_ready", laneReady, 3'b111);
        checkOutput("ar_busy", busy, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        outReady = 1'b1;
        applyStimulus(3'b111, 3'b000, 32'h40, 32'h41, 32'h42, 0, 0, 0);
        tick();
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("ar_first_sel", outSel, 0);
        checkOutput("ar_first_chisq", outChisq, 32'h40);
        tick();
        tick();
        checkOutput("ar_last_sel", outSel, 2);
        tick();
        checkOutput("ar_drain", outValid, 0);

`ifdef CHISQ_CUT_EN
        // Threshold cut drops lane 1
        cutThr = 32'h0000_1000;
        applyStimulus(3'b111, 3'b000, 32'h0800, 32'h2000, 32'h0FFF, 0, 0, 0);
        tick();
        applyStimulus(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("cut_out0_chisq", outChisq, 32'h0800);
        checkOutput("cut_out0_sel", outSel, 0);
        tick();
        checkOutput("cut_drop_valid", outValid, 0);
        checkOutput("cut_rej_cnt", rejCnt, 1);
        tick();
        checkOutput("cut_out2_valid", outValid, 1);
        checkOutput("cut_out2_chisq", outChisq, 32'h0FFF);
        checkOutput("cut_out2_sel", outSel, 2);
        tick();
        checkOutput("cut_drain", outValid, 0);
        cutThr = 32'hFFFF_FFFF;
`endif

        // Overflow counter: popcount add, then saturation
        applyStimulus(3'b111, 3'b111, 32'h1, 32'h2, 32'h3, 0, 0, 0);
        tick();
        checkOutput("sat_pop3", ovfCnt, 3);
        tick();
        checkOutput("sat_hold3", ovfCnt, 3);
        tick();
        checkOutput("sat_inc4", ovfCnt, 4);
        for (int k = 0; k < 65600; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("sat_full", ovfCnt, 16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            tick();
        end
        checkOutput("sat_stays", ovfCnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chisq_out_sched.md
Name: chisq_out_sched

Overview:
Round-robin scheduler that shares one chi-square output stream between three fitter lanes.
- Each lane hands over one chisq result with a valid/ready handshake; the block buffers one result per lane.
- On output, an overflowing lane is replaced by the saturated all-ones value.
- It arbitrates fairly among pending lanes and presents one result per cycle to the downstream track-selection stage, with lane index and tag.

Parameters:
CHISQBITS, 32, width of each chisq value
TAGBITS, 8, width of the per-result track tag carried alongside chisq
OVFCNTBITS, 16, width of the saturating overflow event counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
lane_valid  in  3  per-lane result valid, bit i = lane i
lane_ready  out  3  per-lane ready; bit i = holding register i empty
lane_chisq  in  3*CHISQBITS  packed chisq, lane i at [i*CHISQBITS +: CHISQBITS]
lane_ovf  in  3  per-lane chisq overflow flag
lane_tag  in  3*TAGBITS  packed track tags, same packing as lane_chisq
out_valid  out  1  output result valid
out_ready  in  1  downstream ready
out_chisq  out  CHISQBITS  scheduled chisq, all-ones if overflowed
out_sel  out  2  lane index of current output (00, 01, 10; 11 never driven)
out_tag  out  TAGBITS  tag of current output
ovf_cnt  out  OVFCNTBITS  count of accepted results with ovf=1, saturating
busy  out  1  OR of all lane-full flags and out_valid

Behaviour:
- Clock and reset: single clock domain, clk only. reset_n is asynchronous, active-low, and takes effect immediately on assertion.
- Reset values: lane_full=000, lane_ready=111, out_valid=0, out_chisq=0, out_sel=00, out_tag=0, ovf_cnt=0, busy=0, last_grant=2 (lane 0 gets first priority).
- Lane accept:
  - A lane accepts when lane_valid[i] && lane_ready[i].
  - On accept, hold_chisq[i] is loaded with all-ones if lane_ovf[i], else lane_chisq[i]. hold_tag[i] is loaded, and lane_full[i] is set.
  - lane_ready[i] = ~lane_full[i], registered. There is no same-cycle bypass, so a lane freed at edge N can accept at edge N+1 at the earliest.
- Output load condition: load_en = (~out_valid | out_ready) & (|lane_full).
- Arbitration:
  - When load_en is true, the grant goes to the first full lane in round-robin order starting at last_grant+1 mod 3.
  - At the same edge: out_chisq/out_tag/out_sel are loaded from the granted lane, out_valid is set, lane_full[grant] is cleared, and last_grant is updated.
- Output hold and drain:
  - out_valid && !out_ready: outputs hold stable and no grant occurs.
  - out_ready && no lane full: out_valid clears on the next edge.
- Latency: accept at edge N gives out_valid at edge N+1 if the output slot is free. Sustained throughput is 1 result/cycle with out_ready held high.
- Fairness: with all three lanes continuously full, grants rotate 0,1,2,0,… and no lane waits more than 2 output transfers.
- ovf_cnt: increments on each accept with lane_ovf=1. Simultaneous accepts on multiple lanes add their popcount in one cycle. Saturates at all-ones, with no wrap.
- Simultaneous events:
  - An accept on lane i and a grant of lane i cannot coincide, because ready=~full.
  - An accept on lane j and a grant of lane i (i≠j) in the same cycle are both performed.
- Reset mid-operation: all buffered and in-flight results are discarded and the block returns to reset values.

Optional Feature:
CHISQ_CUT_EN
- Defined:
  - Adds input port cut_thr [CHISQBITS-1:0] and output port rej_cnt [15:0] (saturating, reset 0).
  - A granted result whose stored chisq > cut_thr (unsigned; all-ones always exceeds unless cut_thr is all-ones) is dropped: its lane is freed, the output is not loaded (out_valid follows the normal drain rule), rej_cnt increments, and last_grant still advances.
  - Dropping takes the grant slot for that cycle.
- Undefined: the ports are absent and every result is forwarded.

Test Plan:
- Reset then single result: lane1 chisq=0x00000100, tag=0x5A, ovf=0 at edge 1 → out_valid at edge 2 with out_chisq=0x00000100, out_sel=01, out_tag=0x5A; lane_ready[1] back to 1 at edge 2.
- Overflow saturation: lane2 chisq=0x1234, ovf=1 → out_chisq=0xFFFFFFFF, out_sel=10, ovf_cnt=1. Repeat 70000 times → ovf_cnt stays at 0xFFFF.
- Fairness: all lanes valid every cycle with out_ready=1 → out_sel sequence 00,01,10,00,01,10 and one output per cycle.
- Backpressure: out_ready=0 for 5 cycles with all lanes full → outputs stable, lane_ready=000. Release → three outputs on consecutive cycles, then out_valid=0.
- Async reset mid-stream: assert reset_n low between edges while out_valid=1 and two lanes full → out_valid=0 and lane_ready=111 immediately. After release, the first grant goes to lane 0.
- CHISQ_CUT_EN: cut_thr=0x1000; lanes give 0x0800, 0x2000, 0x0FFF → outputs 0x0800 (sel 00) and 0x0FFF (sel 10) only; rej_cnt=1.
